// File: rtl/fourier_seq_ctrl.sv
// Sequencer for the Fourier DFT datapath: walks every bin k through clear, N-point
// accumulate, MAC drain and result write, then holds done until the next start.
module fourier_seq_ctrl #(
    parameter int N_POINTS = 16,
    parameter int ADDR_W   = 4,
    parameter int MAC_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] sample_addr,
    output logic [ADDR_W-1:0] twiddle_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_POINTS - 1);
    localparam logic [3:0]        DRAIN_LAST = 4'(MAC_LAT - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] n;
    logic [ADDR_W-1:0] tw;
    logic [3:0]        drain;

    // tw tracks (k*n) mod N_POINTS incrementally; the power-of-two length makes the
    // natural ADDR_W wrap the modulo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            k     <= '0;
            n     <= '0;
            tw    <= '0;
            drain <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_CLEAR;
                        k     <= '0;
                    end
                end
                S_CLEAR: begin
                    n     <= '0;
                    tw    <= '0;
                    state <= S_ACCUM;
                end
                S_ACCUM: begin
                    n  <= n + 1'b1;
                    tw <= tw + k;
                    if (n == LAST_IDX) begin
                        drain <= '0;
                        if (MAC_LAT > 0) state <= S_DRAIN;
                        else             state <= S_WRITE;
                    end
                end
                S_DRAIN: begin
                    if (drain == DRAIN_LAST) state <= S_WRITE;
                    else                     drain <= drain + 1'b1;
                end
                S_WRITE: begin
                    if (k == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= S_CLEAR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    always_comb begin
        sample_addr  = '0;
        twiddle_addr = '0;
        res_addr     = '0;
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        res_we       = 1'b0;
        busy         = (state != S_IDLE) && (state != S_DONE);
        done         = (state == S_DONE);
        case (state)
            S_CLEAR: mac_clr = 1'b1;
            S_ACCUM: begin
                mac_en       = 1'b1;
                sample_addr  = n;
                twiddle_addr = tw;
            end
            S_WRITE: begin
                res_we   = 1'b1;
                res_addr = k;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fourier_seq_ctrl.sv
// Self-checking bench for fourier_seq_ctrl: a cycle-position model of the bin schedule
// is compared against two instances (N=16/MAC_LAT=2 and N=8/MAC_LAT=0).
module tb_fourier_seq_ctrl;

    localparam int NA = 16;
    localparam int LA = 2;
    localparam int PA = NA + LA + 2;
    localparam int NB = 8;
    localparam int LB = 0;
    localparam int PB = NB + LB + 2;

    logic clk = 1'b0;
    logic reset_a, start_a, reset_b, start_b;
    logic [3:0] sample_addr_a, twiddle_addr_a, res_addr_a;
    logic [2:0] sample_addr_b, twiddle_addr_b, res_addr_b;
    logic mac_clr_a, mac_en_a, res_we_a, busy_a, done_a;
    logic mac_clr_b, mac_en_b, res_we_b, busy_b, done_b;
    logic [16:0] obs_a, obs_b;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] tw_cap [16][16];
    logic [3:0] tw_bin3 [16] = '{0, 3, 6, 9, 12, 15, 2, 5, 8, 11, 14, 1, 4, 7, 10, 13};
    logic [3:0] tw_bin15 [16] = '{0, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};

    always #5 clk = ~clk;

    fourier_seq_ctrl #(.N_POINTS(NA), .ADDR_W(4), .MAC_LAT(LA)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a),
        .sample_addr(sample_addr_a), .twiddle_addr(twiddle_addr_a),
        .mac_clr(mac_clr_a), .mac_en(mac_en_a), .res_we(res_we_a),
        .res_addr(res_addr_a), .busy(busy_a), .done(done_a)
    );

    fourier_seq_ctrl #(.N_POINTS(NB), .ADDR_W(3), .MAC_LAT(LB)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b),
        .sample_addr(sample_addr_b), .twiddle_addr(twiddle_addr_b),
        .mac_clr(mac_clr_b), .mac_en(mac_en_b), .res_we(res_we_b),
        .res_addr(res_addr_b), .busy(busy_b), .done(done_b)
    );

    assign obs_a = {mac_clr_a, mac_en_a, res_we_a, busy_a, done_a,
                    sample_addr_a, twiddle_addr_a, res_addr_a};
    assign obs_b = {mac_clr_b, mac_en_b, res_we_b, busy_b, done_b,
                    1'b0, sample_addr_b, 1'b0, twiddle_addr_b, 1'b0, res_addr_b};

    // Expected outputs j cycles after the edge that accepted start:
    // {mac_clr, mac_en, res_we, busy, done, sample, twiddle, res_addr}.
    function automatic logic [16:0] model(int np, int lat, int j);
        int p, bin, ph;
        logic clr, en, we, bsy, dn;
        logic [3:0] sa, ta, ra;
        p = np + lat + 2;
        clr = 0; en = 0; we = 0; bsy = 0; dn = 0; sa = 0; ta = 0; ra = 0;
        if (j >= np * p) begin
            dn = 1;
        end else begin
            bsy = 1;
            bin = j / p;
            ph  = j % p;
            if (ph == 0) begin
                clr = 1;
            end else if (ph <= np) begin
                en = 1;
                sa = 4'(ph - 1);
                ta = 4'((bin * (ph - 1)) % np);
            end else if (ph == p - 1) begin
                we = 1;
                ra = 4'(bin);
            end
        end
        return {clr, en, we, bsy, dn, sa, ta, ra};
    endfunction

    task automatic test_reset();
        reset_a = 1; reset_b = 1; start_a = 1; start_b = 1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (obs_a !== 17'h0 || obs_b !== 17'h0) begin
                n_err++;
                $display("FAIL reset_hold a=%h b=%h required=0", obs_a, obs_b);
            end
        end
        start_a = 0; start_b = 0; reset_a = 0; reset_b = 0;
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_busy busy=%b required=1", busy_a);
        end
        @(posedge clk);
        #3;
        reset_a = 1; start_a = 1;
        #1;
        n_cmp++;
        if (obs_a !== 17'h0) begin
            n_err++;
            $display("FAIL reset_async got=%h required=0", obs_a);
        end
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (obs_a !== 17'h0) begin
                n_err++;
                $display("FAIL reset_idle_held got=%h required=0", obs_a);
            end
        end
        reset_a = 0; start_a = 0;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (obs_a !== 17'h0) begin
                n_err++;
                $display("FAIL reset_released_idle got=%h required=0", obs_a);
            end
        end
    endtask

    task automatic test_full_transform();
        int n_we, n_clr, n_en, next_ra;
        logic [16:0] exp;
        n_we = 0; n_clr = 0; n_en = 0; next_ra = 0;
        @(negedge clk);
        start_a = 1;
        for (int j = 0; j <= NA * PA; j++) begin
            @(negedge clk);
            start_a = (j < NA * PA) && ((j == 4 * PA + 5) || ($urandom_range(0, 7) == 0));
            exp = model(NA, LA, j);
            n_cmp++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL full_cycle j=%0d got=%h required=%h", j, obs_a, exp);
            end
            if (mac_en_a === 1'b1) begin
                tw_cap[(j / PA) % 16][sample_addr_a] = twiddle_addr_a;
                n_en++;
            end
            if (mac_clr_a === 1'b1) n_clr++;
            if (res_we_a === 1'b1) begin
                n_cmp++;
                if (res_addr_a !== 4'(next_ra)) begin
                    n_err++;
                    $display("FAIL full_res_order got=%0d required=%0d", res_addr_a, next_ra);
                end
                next_ra++;
                n_we++;
            end
        end
        start_a = 0;
        n_cmp++;
        if (n_we != 16 || n_clr != 16 || n_en != 256) begin
            n_err++;
            $display("FAIL full_counts we=%0d clr=%0d en=%0d required=16/16/256", n_we, n_clr, n_en);
        end
        n_cmp++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL full_done_320 done=%b busy=%b required=1/0", done_a, busy_a);
        end
    endtask

    task automatic test_twiddle_wrap();
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (tw_cap[3][i] !== tw_bin3[i] || tw_cap[15][i] !== tw_bin15[i] || tw_cap[0][i] !== 4'd0) begin
                n_err++;
                $display("FAIL twiddle n=%0d got=%0d/%0d/%0d required=%0d/%0d/0", i,
                         tw_cap[3][i], tw_cap[15][i], tw_cap[0][i], tw_bin3[i], tw_bin15[i]);
            end
        end
    endtask

    task automatic test_start_in_done();
        logic [16:0] exp;
        int gap;
        gap = $urandom_range(0, 3);
        repeat (gap) begin
            @(negedge clk);
            n_cmp++;
            if (obs_a !== model(NA, LA, NA * PA)) begin
                n_err++;
                $display("FAIL done_hold got=%h required=%h", obs_a, model(NA, LA, NA * PA));
            end
        end
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        n_cmp++;
        if (done_a !== 1'b0 || mac_clr_a !== 1'b1) begin
            n_err++;
            $display("FAIL done_restart done=%b mac_clr=%b required=0/1", done_a, mac_clr_a);
        end
        for (int j = 1; j <= NA * PA; j++) begin
            @(negedge clk);
            exp = model(NA, LA, j);
            n_cmp++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL restart_cycle j=%0d got=%h required=%h", j, obs_a, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        @(negedge clk);
        start_a = 1;
        for (int j = 0; j <= NA * PA; j++) begin
            @(negedge clk);
            exp = model(NA, LA, j);
            n_cmp++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL b2b_first j=%0d got=%h required=%h", j, obs_a, exp);
            end
        end
        for (int j = 0; j <= NA * PA; j++) begin
            @(negedge clk);
            if (j == 2 * PA) start_a = 0;
            exp = model(NA, LA, j);
            n_cmp++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL b2b_second j=%0d got=%h required=%h", j, obs_a, exp);
            end
        end
        start_a = 0;
    endtask

    task automatic test_reset_in_drain();
        logic [16:0] exp;
        int n_we, stop_j;
        n_we = 0;
        stop_j = 7 * PA + NA + 1;
        @(negedge clk);
        start_a = 1;
        for (int j = 0; j <= stop_j; j++) begin
            @(negedge clk);
            start_a = 0;
            exp = model(NA, LA, j);
            n_cmp++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL drain_run j=%0d got=%h required=%h", j, obs_a, exp);
            end
            if (res_we_a === 1'b1) n_we++;
        end
        #2;
        reset_a = 1;
        #1;
        n_cmp++;
        if (obs_a !== 17'h0) begin
            n_err++;
            $display("FAIL drain_reset got=%h required=0", obs_a);
        end
        repeat (2) begin
            @(negedge clk);
            if (res_we_a === 1'b1) n_we++;
        end
        n_cmp++;
        if (n_we != 7) begin
            n_err++;
            $display("FAIL drain_we_count got=%0d required=7", n_we);
        end
        reset_a = 0;
        @(negedge clk);
        start_a = 1;
        n_we = 0;
        for (int j = 0; j <= NA * PA; j++) begin
            @(negedge clk);
            start_a = 0;
            exp = model(NA, LA, j);
            n_cmp++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL drain_rerun j=%0d got=%h required=%h", j, obs_a, exp);
            end
            if (res_we_a === 1'b1) n_we++;
        end
        n_cmp++;
        if (n_we != 16) begin
            n_err++;
            $display("FAIL drain_rerun_we got=%0d required=16", n_we);
        end
    endtask

    task automatic test_mac_lat0();
        logic [16:0] exp;
        logic prev_en;
        int n_direct;
        prev_en = 0;
        n_direct = 0;
        @(negedge clk);
        start_b = 1;
        for (int j = 0; j <= NB * PB; j++) begin
            @(negedge clk);
            start_b = (j < NB * PB) && ($urandom_range(0, 5) == 0);
            exp = model(NB, LB, j);
            n_cmp++;
            if (obs_b !== exp) begin
                n_err++;
                $display("FAIL lat0_cycle j=%0d got=%h required=%h", j, obs_b, exp);
            end
            if (res_we_b === 1'b1 && prev_en) n_direct++;
            prev_en = mac_en_b;
        end
        start_b = 0;
        n_cmp++;
        if (n_direct != 8 || done_b !== 1'b1) begin
            n_err++;
            $display("FAIL lat0_direct_write writes=%0d done=%b required=8/1", n_direct, done_b);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_transform();
        test_twiddle_wrap();
        test_start_in_done();
        test_back_to_back();
        test_reset_in_drain();
        test_mac_lat0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
